// File: rtl/obuft_pkg.sv
// obuft_pkg: shared constants for the registered tristate pad buffer bank.
//   OBUFT_DRIVE / OBUFT_RELEASE : encoding of the tristate control T.
//                                 0 drives the pad, 1 releases it.
//   OBUFT_DQ_WIDTH              : default bank width, one DQ byte pair.
//   OBUFT_DQS_WIDTH             : width of a single strobe buffer.
package obuft_pkg;
  localparam logic OBUFT_DRIVE     = 1'b0;
  localparam logic OBUFT_RELEASE   = 1'b1;
  localparam int   OBUFT_DQ_WIDTH  = 16;
  localparam int   OBUFT_DQS_WIDTH = 1;
endpackage

// File: rtl/obuft_cell.sv
// obuft_cell: one pad bit of the tristate output buffer.
//   Each cell keeps its own copy of the tristate flop, so every pad can
//   pack its data and enable flops into its own IOB.
// Ports:
//   CLK  in   controller clock
//   RST  in   asynchronous active-high reset
//   I    in   data to drive (rise data in DDR mode)
//   I_F  in   fall data, present only when OBUFT_DDR_EN is defined
//   T    in   tristate control, 1 = release, 0 = drive
//   O    out  tri-stated pad bit
// Parameters:
//   INIT     data flop value after reset
//   REG_OUT  1 = registered I/T, 0 = combinational pass-through
// Build macro: OBUFT_DDR_EN adds the fall-data path (REG_OUT=1 only).
module obuft_cell
  import obuft_pkg::*;
#(
  parameter bit INIT    = 1'b0,
  parameter bit REG_OUT = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
`ifdef OBUFT_DDR_EN
  input  logic I_F,
`endif
  input  logic T,
  output logic O
);

  if (REG_OUT) begin : g_reg
    logic dat_d, dat_q;
    logic tri_d, tri_q;
    logic dat_out;

    always_comb begin
      dat_d = I;
      tri_d = T;
    end

    // Reset releases the pad immediately; a new drive needs T=0 sampled
    // after reset is gone.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        dat_q <= INIT;
        tri_q <= OBUFT_RELEASE;
      end else begin
        dat_q <= dat_d;
        tri_q <= tri_d;
      end
    end

`ifdef OBUFT_DDR_EN
    // Fall data is captured with the rise data at posedge, then moved to a
    // negedge flop so it is stable for the whole low phase.
    logic fpre_d, fpre_q;
    logic fall_d, fall_q;

    always_comb begin
      fpre_d = I_F;
      fall_d = fpre_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) fpre_q <= INIT;
      else     fpre_q <= fpre_d;
    end

    always_ff @(negedge CLK or posedge RST) begin
      if (RST) fall_q <= INIT;
      else     fall_q <= fall_d;
    end

    // Clock-selected mux: rise data while CLK high, fall data while low.
    assign dat_out = CLK ? dat_q : fall_q;
`else
    assign dat_out = dat_q;
`endif

    // An unknown enable merges Z with the data, so O goes X, never a drive.
    assign O = (tri_q == OBUFT_DRIVE) ? dat_out : 1'bz;
  end else begin : g_comb
    // No state in this mode; clock, reset and fall data are intentionally
    // left unused.
    logic unused_in;
`ifdef OBUFT_DDR_EN
    assign unused_in = CLK ^ RST ^ I_F;
`else
    assign unused_in = CLK ^ RST;
`endif
    assign O = (T == OBUFT_DRIVE) ? I : 1'bz;
  end

endmodule

// File: rtl/obuft.sv
// obuft: registered tristate output buffer bank for bidirectional SDRAM pads
//   (DQ, LDQS/UDQS). Drives O from I while T is low, releases O (Z) while T
//   is high. All bits share one T; each bit is an obuft_cell.
// Ports:
//   CLK  in   1      controller clock
//   RST  in   1      asynchronous active-high reset (O released at once)
//   I    in   WIDTH  data to drive (rise data in DDR mode)
//   I_F  in   WIDTH  fall data, only when OBUFT_DDR_EN is defined
//   T    in   1      tristate control, 1 = release, 0 = drive
//   O    out  WIDTH  tri-stated pad output
// Parameters:
//   WIDTH    number of pad bits
//   INIT     reset value of the data flops, replicated to every bit
//   REG_OUT  1 = one-cycle registered path, 0 = combinational, no state
// Build macro: OBUFT_DDR_EN adds I_F and double-data-rate output
//   (meaningful only with REG_OUT=1).
module obuft
  import obuft_pkg::*;
#(
  parameter int WIDTH   = OBUFT_DQ_WIDTH,
  parameter bit INIT    = 1'b0,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
`ifdef OBUFT_DDR_EN
  input  logic [WIDTH-1:0] I_F,
`endif
  input  logic             T,
  output logic [WIDTH-1:0] O
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    obuft_cell #(
      .INIT    (INIT),
      .REG_OUT (REG_OUT)
    ) u_cell (
      .CLK (CLK),
      .RST (RST),
      .I   (I[g]),
`ifdef OBUFT_DDR_EN
      .I_F (I_F[g]),
`endif
      .T   (T),
      .O   (O[g])
    );
  end

endmodule

// File: tb/tb_obuft.sv
// tb_obuft: scoreboard bench for obuft. Each configuration (16-bit
// registered, 16-bit combinational, 1-bit registered strobe) is built twice,
// once onto a pulled-up net and once onto a pulled-down net: a released pad
// reads all-ones/all-zeros, a driven pad reads the same value on both.
module tb_obuft;
  import obuft_pkg::*;

  localparam int W = OBUFT_DQ_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_s;
  logic [W-1:0] if_s;
  logic         t_s;

  tri1 [W-1:0] o_up;
  tri0 [W-1:0] o_dn;
  tri1 [W-1:0] oc_up;
  tri0 [W-1:0] oc_dn;
  tri1 [OBUFT_DQS_WIDTH-1:0] q_up;
  tri0 [OBUFT_DQS_WIDTH-1:0] q_dn;

`ifndef OBUFT_DDR_EN
  logic unused_if;
  assign unused_if = ^if_s;
`endif

  always #10 clk = ~clk;

  obuft #(.WIDTH(W), .INIT(1'b0), .REG_OUT(1'b1)) u_dq_up (
    .CLK(clk), .RST(rst), .I(i_s),
`ifdef OBUFT_DDR_EN
    .I_F(if_s),
`endif
    .T(t_s), .O(o_up));
  obuft #(.WIDTH(W), .INIT(1'b0), .REG_OUT(1'b1)) u_dq_dn (
    .CLK(clk), .RST(rst), .I(i_s),
`ifdef OBUFT_DDR_EN
    .I_F(if_s),
`endif
    .T(t_s), .O(o_dn));
  obuft #(.WIDTH(W), .INIT(1'b0), .REG_OUT(1'b0)) u_cb_up (
    .CLK(clk), .RST(rst), .I(i_s),
`ifdef OBUFT_DDR_EN
    .I_F(if_s),
`endif
    .T(t_s), .O(oc_up));
  obuft #(.WIDTH(W), .INIT(1'b0), .REG_OUT(1'b0)) u_cb_dn (
    .CLK(clk), .RST(rst), .I(i_s),
`ifdef OBUFT_DDR_EN
    .I_F(if_s),
`endif
    .T(t_s), .O(oc_dn));
  obuft #(.WIDTH(OBUFT_DQS_WIDTH), .INIT(1'b0), .REG_OUT(1'b1)) u_qs_up (
    .CLK(clk), .RST(rst), .I(i_s[0:0]),
`ifdef OBUFT_DDR_EN
    .I_F(if_s[0:0]),
`endif
    .T(t_s), .O(q_up));
  obuft #(.WIDTH(OBUFT_DQS_WIDTH), .INIT(1'b0), .REG_OUT(1'b1)) u_qs_dn (
    .CLK(clk), .RST(rst), .I(i_s[0:0]),
`ifdef OBUFT_DDR_EN
    .I_F(if_s[0:0]),
`endif
    .T(t_s), .O(q_dn));

  // unit: 0 = 16-bit registered, 1 = 16-bit combinational, 2 = 1-bit strobe
  typedef struct {
    string        name;
    int           unit;
    logic         rel;
    logic [W-1:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event chk_ev;

  task automatic push(input string nm, input int u, input logic rel,
                      input logic [W-1:0] v);
    exp_t e;
    e.name = nm; e.unit = u; e.rel = rel; e.val = v;
    q.push_back(e);
  endtask

  task automatic expect_reg(input string nm, input logic rel, input logic [W-1:0] v);
    push({nm, "_dq"}, 0, rel, v);
    push({nm, "_dqs"}, 2, rel, v);
  endtask

  task automatic expect_comb(input string nm, input logic rel, input logic [W-1:0] v);
    push({nm, "_comb"}, 1, rel, v);
  endtask

  // Hand the queued expectations to the monitor and let it sample before
  // the stimulus moves on.
  task automatic fire();
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every presentation point, pop and compare all pending items.
  initial begin
    exp_t         e;
    logic [W-1:0] up, dn, mask;
    bit           ok;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.unit)
          0:       begin up = o_up;     dn = o_dn;     mask = '1; end
          1:       begin up = oc_up;    dn = oc_dn;    mask = '1; end
          default: begin up = W'(q_up); dn = W'(q_dn); mask = W'(1); end
        endcase
        if (e.rel) ok = ((up & mask) == mask) && ((dn & mask) == '0);
        else       ok = ((up & mask) == (e.val & mask)) && ((dn & mask) == (e.val & mask));
        n_tests++;
        if (!ok) begin
          n_fail++;
          if (e.rel)
            $display("FAIL %s: pullup=%h pulldown=%h, required released (Z)",
                     e.name, up & mask, dn & mask);
          else
            $display("FAIL %s: pullup=%h pulldown=%h, required driven %h",
                     e.name, up & mask, dn & mask, e.val & mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    i_s  = 16'hBABE;
    if_s = 16'hBABE;
    t_s  = 1'b0;
    #1;
    // Reset with T=0 and data present: registered pads release at once,
    // the stateless buffer drives regardless.
    expect_reg("rst_async", 1'b1, '0);
    expect_comb("rst_comb", 1'b0, 16'hBABE);
    fire();

    tick(); tick();
    expect_reg("rst_held", 1'b1, '0); fire();
    rst = 1'b0;
    expect_reg("rst_rel_wait", 1'b1, '0); fire();
    tick();
    expect_reg("rst_first_drive", 1'b0, 16'hBABE); fire();

    // Data-only change: one-cycle latency.
    i_s = 16'h1234; if_s = 16'h1234;
    expect_reg("drv_latency", 1'b0, 16'hBABE);
    expect_comb("drv_comb", 1'b0, 16'h1234);
    fire();
    tick();
    expect_reg("drv_1234", 1'b0, 16'h1234); fire();

    // Release: Z on the next edge; data changes while released stay hidden.
    t_s = 1'b1; i_s = 16'h5555;
    expect_reg("rel_latency", 1'b0, 16'h1234);
    expect_comb("rel_comb", 1'b1, '0);
    fire();
    tick();
    expect_reg("rel_z", 1'b1, '0); fire();
    i_s = 16'hAAAA;
    tick();
    expect_reg("rel_hold_z", 1'b1, '0); fire();

    // T 1->0 with new data: new data on the same edge, no stale drive.
    t_s = 1'b0; i_s = 16'h0F0F;
    expect_reg("sim_pre", 1'b1, '0);
    expect_comb("sim_comb", 1'b0, 16'h0F0F);
    fire();
    tick();
    expect_reg("sim_new", 1'b0, 16'h0F0F); fire();

    // Asynchronous reset in the middle of a drive cycle.
    i_s = 16'hBABE;
    tick();
    expect_reg("mid_drive", 1'b0, 16'hBABE); fire();
    rst = 1'b1;
    #1;
    expect_reg("async_mid", 1'b1, '0);
    expect_comb("async_comb", 1'b0, 16'hBABE);
    fire();
    t_s = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    expect_reg("post_rst_t1", 1'b1, '0); fire();
    t_s = 1'b0;
    expect_reg("post_rst_pre", 1'b1, '0); fire();
    tick();
    expect_reg("post_rst_drive", 1'b0, 16'hBABE); fire();

`ifdef OBUFT_DDR_EN
    i_s = 16'hBABE; if_s = 16'hCAFE;
    tick();
    expect_reg("ddr_rise", 1'b0, 16'hBABE); fire();
    @(negedge clk);
    #1;
    expect_reg("ddr_fall", 1'b0, 16'hCAFE); fire();
    tick();
    expect_reg("ddr_rise2", 1'b0, 16'hBABE); fire();
`endif

    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
